count_bcd_display: RTL and testbench

COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

---
 rtl/count_disp_pkg.sv | 50 +++++
 rtl/seg7_decode.sv | 33 +++
 rtl/count_bcd_display.sv | 154 +++++++++++++++
 tb/tb_count_bcd_display.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_disp_pkg.sv
// count_disp_pkg: shared types and constants for count_bcd_display.
//   - conversion FSM state enum
//   - active-low 7-segment patterns {g,f,e,d,c,b,a} for 0-9, blank, minus
//   - digit count and datapath widths
//   - dd_step: one double-dabble iteration on a {bcd[11:0], bin[7:0]} word
package count_disp_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned BCD_W      = 12;
  localparam int unsigned ACC_W      = BCD_W + DATA_W;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned ITER_W     = 3;
  localparam int unsigned PRESC_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

  // Decoder code reserved for the sign digit.
  localparam logic [3:0] CODE_MINUS = 4'hA;

  // Add 3 to every BCD nibble >= 5, then shift the whole word left by one.
  function automatic logic [ACC_W-1:0] dd_step(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] adj;
    adj = acc;
    for (int i = 0; i < 3; i++) begin
      if (adj[DATA_W + 4*i +: 4] >= 4'd5)
        adj[DATA_W + 4*i +: 4] = adj[DATA_W + 4*i +: 4] + 4'd3;
    end
    return {adj[ACC_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit digit code plus blank flag to active-low 7-segment pattern.
//   code  : 0-9 digits, CODE_MINUS for "-", anything else blank
//   blank : forces all segments off
//   seg_c : {g,f,e,d,c,b,a}, active low (combinational)
module seg7_decode
  import count_disp_pkg::*;
(
  input  logic [3:0]       code,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (code)
        4'd0:       seg_c = SEG_0;
        4'd1:       seg_c = SEG_1;
        4'd2:       seg_c = SEG_2;
        4'd3:       seg_c = SEG_3;
        4'd4:       seg_c = SEG_4;
        4'd5:       seg_c = SEG_5;
        4'd6:       seg_c = SEG_6;
        4'd7:       seg_c = SEG_7;
        4'd8:       seg_c = SEG_8;
        4'd9:       seg_c = SEG_9;
        CODE_MINUS: seg_c = SEG_MINUS;
        default:    seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display: converts an 8-bit counter value to BCD with a sequential
// double-dabble FSM and scans the result onto a 4-digit multiplexed display.
//   clk, rst  : clock, asynchronous active-high reset
//   count_in  : counter value, sampled once per conversion in IDLE
//   bcd       : latched {hundreds, tens, ones}
//   bcd_valid : one-cycle pulse when bcd updates
//   seg       : active-low segments {g,f,e,d,c,b,a} for the selected digit
//   an        : active-low digit enables, an[0] = ones, an[3] = sign digit
// Parameter SCAN_DIV: clk cycles per digit slot (2..65535).
// Macro COUNT_SIGNED_EN: treat count_in as two's complement, show "-" on an[3].
module count_bcd_display
  import count_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     count_in,
  output logic [BCD_W-1:0]      bcd,
  output logic                  bcd_valid,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] an
);

  state_t              state, state_nxt;
  logic [ACC_W-1:0]    acc;
  logic [ITER_W-1:0]   iter;
  logic                sign_cap;
  logic                sign;
  logic                shown;
  logic [PRESC_W-1:0]  presc;
  logic [DIGIT_W-1:0]  digit;
  logic [DATA_W-1:0]   mag_c;
  logic                neg_c;
  logic [3:0]          code_c;
  logic                blank_c;
  logic [SEG_W-1:0]    seg_c;

  // Magnitude and sign of the incoming value (-128 maps to 128).
`ifdef COUNT_SIGNED_EN
  assign neg_c = count_in[DATA_W-1];
  assign mag_c = neg_c ? DATA_W'(~count_in + 8'd1) : count_in;
`else
  assign neg_c = 1'b0;
  assign mag_c = count_in;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: IDLE 1 cycle, SHIFT 8 cycles, LATCH 1 cycle, repeating.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (iter == ITER_W'(7)) state_nxt = ST_LATCH;
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Conversion datapath; bcd only changes in LATCH so partial results never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      iter      <= '0;
      sign_cap  <= 1'b0;
      bcd       <= '0;
      sign      <= 1'b0;
      bcd_valid <= 1'b0;
      shown     <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          acc      <= {BCD_W'(0), mag_c};
          iter     <= '0;
          sign_cap <= neg_c;
        end
        ST_SHIFT: begin
          acc  <= dd_step(acc);
          iter <= iter + ITER_W'(1);
        end
        ST_LATCH: begin
          bcd       <= acc[ACC_W-1:DATA_W];
          sign      <= sign_cap;
          bcd_valid <= 1'b1;
          shown     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scan prescaler and digit index; idle at digit 0 until the first result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      digit <= '0;
    end else if (shown) begin
      if (presc == PRESC_W'(SCAN_DIV - 1)) begin
        presc <= '0;
        digit <= digit + DIGIT_W'(1);
      end else begin
        presc <= presc + PRESC_W'(1);
      end
    end
  end

  // Digit mux with leading-zero blanking.
  always_comb begin
    code_c  = 4'd0;
    blank_c = 1'b1;
    case (digit)
      2'd0: begin
        code_c  = bcd[3:0];
        blank_c = 1'b0;
      end
      2'd1: begin
        code_c  = bcd[7:4];
        blank_c = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      2'd2: begin
        code_c  = bcd[11:8];
        blank_c = (bcd[11:8] == 4'd0);
      end
      default: begin
        code_c  = CODE_MINUS;
        blank_c = !sign;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .code  (code_c),
    .blank (blank_c),
    .seg_c (seg_c)
  );

  // Registered display drive; an and seg always move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else if (shown) begin
      seg <= seg_c;
      an  <= ~(NUM_DIGITS'(1) << digit);
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display: randomized and directed stimulus for count_bcd_display
// (SCAN_DIV = 4), checked against an arithmetic reference model.
// Honors COUNT_SIGNED_EN the same way as the design.
module tb_count_bcd_display;

  localparam int unsigned SCAN_DIV = 4;

`ifdef COUNT_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  count_in = 8'd0;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [3:0]  an;

  count_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: cycle number since reset release, captured and latched values.
  int         cyc     = 0;
  int         cap_val = 0;
  bit         cap_neg = 1'b0;
  int         lat_val = 0;
  bit         lat_neg = 1'b0;
  bit         exp_valid = 1'b0;
  logic [3:0] exp_an  = 4'hF;
  logic [6:0] exp_seg = 7'h7F;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int mag_of(input logic [7:0] x);
    if (SIGNED_MODE && x[7]) return 256 - int'(x);
    return int'(x);
  endfunction

  function automatic bit neg_of(input logic [7:0] x);
    return SIGNED_MODE && x[7];
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pattern of display position d for value v.
  function automatic logic [6:0] digit_seg(input int d, input int v, input bit neg);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (d)
      0: return pat(o);
      1: return (h == 0 && t == 0) ? 7'h7F : pat(t);
      2: return (h == 0) ? 7'h7F : pat(h);
      default: return neg ? 7'b0111111 : 7'h7F;
    endcase
  endfunction

  // One clock: update the model at the rising edge, check at the falling edge.
  task automatic step();
    int d;
    @(posedge clk);
    if (rst) begin
      cyc = 0; lat_val = 0; lat_neg = 1'b0; exp_valid = 1'b0;
      exp_an = 4'hF; exp_seg = 7'h7F;
    end else begin
      cyc++;
      // Display: first result appears at edge 10, scan starts on the next edge.
      if (cyc >= 11) begin
        d = ((cyc - 11) / SCAN_DIV) % 4;
        exp_an  = ~(4'b0001 << d);
        exp_seg = digit_seg(d, lat_val, lat_neg);
      end else begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end
      // A conversion is 10 cycles: capture on edges 1, 11, 21..., result on 10, 20, ...
      exp_valid = (cyc % 10 == 0);
      if (cyc % 10 == 1) begin
        cap_val = mag_of(count_in);
        cap_neg = neg_of(count_in);
      end
      if (exp_valid) begin
        lat_val = cap_val;
        lat_neg = cap_neg;
      end
    end
    @(negedge clk);
    check_eq("bcd", 32'(bcd), 32'(to_bcd(lat_val)));
    check_eq("bcd_valid", 32'(bcd_valid), 32'(exp_valid));
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
  endtask

  task automatic run(input logic [7:0] v, input int n);
    count_in = v;
    repeat (n) step();
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bcd_valid && k < 20);
    check_eq(tag, 32'(bcd_valid), 32'd1);
  endtask

  initial begin
    // Reset hold.
    repeat (3) step();
    check_eq("rst_bcd", 32'(bcd), 32'h000);
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_seg", 32'(seg), 32'h7F);

    // Zero input: first pulse exactly 10 cycles after release, digit 0 shows "0".
    rst = 1'b0;
    run(8'd0, 10);
    check_eq("zero_valid_at_10", 32'(bcd_valid), 32'd1);
    check_eq("zero_bcd", 32'(bcd), 32'h000);
    step();
    check_eq("zero_an0", 32'(an), 32'b1110);
    check_eq("zero_seg0", 32'(seg), 32'b1000000);
    repeat (29) step();

    // Full-scale value through several complete scans.
    run(8'd255, 60);
    check_eq("bcd_255", 32'(bcd), 32'h255);

    // Single digit: upper digits blank while an keeps cycling.
    run(8'd7, 40);
    check_eq("bcd_7", 32'(bcd), 32'h007);

    // Input change during SHIFT is ignored until the next IDLE.
    count_in = 8'd10;
    step();
    begin
      int k;
      k = 0;
      while (cyc % 10 != 1 && k < 12) begin step(); k++; end
    end
    step();
    step();
    count_in = 8'd99;
    wait_valid("shift_change_first_valid");
    check_eq("shift_change_bcd_010", 32'(bcd), 32'h010);
    wait_valid("shift_change_second_valid");
    check_eq("shift_change_bcd_099", 32'(bcd), 32'h099);

    // Random values changing at random times.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) count_in = 8'($urandom);
      step();
    end

    // Asynchronous reset during SHIFT: immediate clear, no pulse.
    run(8'd200, 20);
    begin
      int k;
      k = 0;
      while (cyc % 10 != 6 && k < 12) begin step(); k++; end
    end
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_bcd", 32'(bcd), 32'h000);
    check_eq("async_rst_valid", 32'(bcd_valid), 32'd0);
    check_eq("async_rst_an", 32'(an), 32'hF);
    check_eq("async_rst_seg", 32'(seg), 32'h7F);
    repeat (4) step();
    rst = 1'b0;
    run(8'd42, 30);
    check_eq("after_rst_bcd_042", 32'(bcd), 32'h042);

    // Negative-number boundaries (magnitude in unsigned builds).
    run(8'h80, 40);
    check_eq("bcd_80", 32'(bcd), SIGNED_MODE ? 32'h128 : 32'h128);
    run(8'hFF, 40);
    check_eq("bcd_ff", 32'(bcd), SIGNED_MODE ? 32'h001 : 32'h255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
